swap_regfile_ctrl: RTL and testbench
====================================

// Module: swap_regfile_ctrl
// PURPOSE
//   Initiator-side sequencer for swap_regfile. On one start pulse it exchanges the
//   contents of two register entries using only the regfile's single read port and
//   single write port: read A, read B, write B->A, write A->B.
//   It sits between the LFSR control logic (requester) and swap_regfile (target),
//   and owns the regfile's r_addr/w_addr/din/wr_en for the whole operation.
// PARAMETERS
//   ADDR_W   5   regfile address width (32 entries)
//   DATA_W   8   regfile data width
//   RD_LAT   1   cycles from rf_r_addr change to valid rf_dout (0 = combinational read)
// PORTS
//   clk         in   1       system clock, rising edge
//   rst_n       in   1       reset
//   start       in   1       request pulse, sampled only in IDLE
//   addr_a      in   ADDR_W  first entry, latched when start is accepted
//   addr_b      in   ADDR_W  second entry, latched when start is accepted
//   busy        out  1       high from the cycle after acceptance through DONE
//   done        out  1       one-cycle completion pulse
//   rf_r_addr   out  ADDR_W  to swap_regfile r_addr
//   rf_dout     in   DATA_W  from swap_regfile dout
//   rf_w_addr   out  ADDR_W  to swap_regfile w_addr
//   rf_din      out  DATA_W  to swap_regfile din
//   rf_wr_en    out  1       to swap_regfile wr_en
// BEHAVIOUR
// - Clocking/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
// - Reset values: state = IDLE; busy, done and rf_wr_en = 0; rf_r_addr, rf_w_addr
//   and rf_din = 0; latched addresses and data = 0. rf_wr_en drops with rst_n, not at a clock edge.
// - FSM states: IDLE, RD_A, WAIT_A, RD_B, WAIT_B, WR_A, WR_B, DONE.
// - IDLE: if start=1, latch addr_a/addr_b. If addr_a!=addr_b, go to RD_A.
//   If addr_a==addr_b, go to DONE with no regfile write (no-op swap).
// - RD_A: drive rf_r_addr=A for 1 cycle, then go to WAIT_A.
// - WAIT_A: hold rf_r_addr=A for RD_LAT cycles using a down-counter. On the last
//   cycle, capture rf_dout into val_a, then go to RD_B. If RD_LAT=0, WAIT_A is skipped
//   and val_a is captured at the end of RD_A.
// - RD_B/WAIT_B: same as RD_A/WAIT_A for address B; capture into val_b.
// - WR_A: rf_w_addr=A, rf_din=val_b, rf_wr_en=1 for exactly one cycle.
// - WR_B: rf_w_addr=B, rf_din=val_a, rf_wr_en=1 for exactly one cycle.
// - DONE: done=1 for one cycle, then return to IDLE. start is ignored in DONE.
// - Latency with start accepted at cycle T:
//   - Swap: busy covers T+1 .. T+4+2*RD_LAT; done is high in the last of those
//     cycles (T+6 for RD_LAT=1).
//   - No-op: busy=1 and done=1 in T+1 only.
// - rf_r_addr holds its last value when idle; it is don't-care to the regfile.
// - rf_wr_en is never high outside WR_A/WR_B. There are never two writes in one cycle.
// - start while busy=1 is ignored, not queued. addr_a/addr_b changes after
//   acceptance have no effect.
// - Addresses are used as-is, modulo 2^ADDR_W. Entries 0 and 31 are legal; there is no wrap logic.
// - Reset mid-operation: the FSM goes to IDLE immediately. A write already committed
//   at a prior edge stays; no further write occurs. If reset hits during WR_B, entry A
//   holds the old B value and entry B is unchanged.
// TESTING
// 1. Preload reg3=0xAB, reg7=0xCD, RD_LAT=1; start with a=3, b=7 ->
//    - done at T+6;
//    - reg3=0xCD, reg7=0xAB;
//    - exactly 2 rf_wr_en cycles.
// 2. start with a=b=5, reg5=0x5A ->
//    - busy=done=1 at T+1 only;
//    - rf_wr_en never asserted;
//    - reg5 stays 0x5A.
// 3. Issue start with a=0, b=31 (0x11/0x22), then pulse start again with a=1, b=2
//    at T+2 and in the DONE cycle ->
//    - only the first swap happens: reg0=0x22, reg31=0x11;
//    - reg1/reg2 are untouched.
// 4. Repeat scenario 1 and assert rst_n=0 mid-WR_B ->
//    - rf_wr_en=0 asynchronously;
//    - reg3=0xCD, reg7=0xCD;
//    - FSM is IDLE, done never pulses.
// 5. Back-to-back: swap (3,7), then restart in the first IDLE cycle after done ->
//    - original values are restored: reg3=0xAB, reg7=0xCD.
// 6. Build with RD_LAT=0 and a combinational-read model; repeat scenario 1 ->
//    - done at T+4;
//    - same final contents.

Source files
------------

// File: rtl/swap_regfile_ctrl.sv
// Exchanges two swap_regfile entries via one read and one write port; busy for 4+2*RD_LAT cycles (1 for a==b).
// No backpressure: start is taken only in IDLE, and requests arriving while busy are dropped.
module swap_regfile_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rf_r_addr,
    input  logic [DATA_W-1:0] rf_dout,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_din,
    output logic              rf_wr_en
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT_A = 3'd1;
    localparam logic [2:0] RD_B   = 3'd2;
    localparam logic [2:0] WAIT_B = 3'd3;
    localparam logic [2:0] WR_A   = 3'd4;
    localparam logic [2:0] WR_B   = 3'd5;
    localparam logic [2:0] DONE   = 3'd6;

    localparam int CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int LOAD_I = (RD_LAT > 0) ? RD_LAT - 1 : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD = LOAD_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [ADDR_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] val_a_q, val_a_d;
    logic [DATA_W-1:0] val_b_q, val_b_d;
    logic [ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              wr_en_q, wr_en_d;
    logic              accept;

    assign accept = (state_q == IDLE) && start;

    // The read of A is issued in the accepting cycle itself, so it needs no state of its own.
    assign rf_r_addr = accept ? addr_a : r_addr_q;
    assign rf_w_addr = w_addr_q;
    assign rf_din    = din_q;
    assign rf_wr_en  = wr_en_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        val_a_d  = val_a_q;
        val_b_d  = val_b_q;
        r_addr_d = r_addr_q;
        w_addr_d = w_addr_q;
        din_d    = din_q;
        wr_en_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d = addr_a;
                    b_d = addr_b;
                    if (addr_a == addr_b) begin
                        state_d = DONE;
                    end else if (RD_LAT == 0) begin
                        val_a_d  = rf_dout;
                        r_addr_d = addr_b;
                        state_d  = RD_B;
                    end else begin
                        r_addr_d = addr_a;
                        cnt_d    = CNT_LOAD;
                        state_d  = WAIT_A;
                    end
                end
            end
            WAIT_A: begin
                if (cnt_q == '0) begin
                    val_a_d  = rf_dout;
                    r_addr_d = b_q;
                    state_d  = RD_B;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RD_B: begin
                if (RD_LAT == 0) begin
                    val_b_d  = rf_dout;
                    w_addr_d = a_q;
                    din_d    = val_b_d;
                    wr_en_d  = 1'b1;
                    state_d  = WR_A;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (cnt_q == '0) begin
                    val_b_d  = rf_dout;
                    w_addr_d = a_q;
                    din_d    = val_b_d;
                    wr_en_d  = 1'b1;
                    state_d  = WR_A;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            WR_A: begin
                w_addr_d = b_q;
                din_d    = val_a_q;
                wr_en_d  = 1'b1;
                state_d  = WR_B;
            end
            WR_B:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write strobe is a flop on the async reset, so it drops the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            val_a_q  <= '0;
            val_b_q  <= '0;
            r_addr_q <= '0;
            w_addr_q <= '0;
            din_q    <= '0;
            wr_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            val_a_q  <= val_a_d;
            val_b_q  <= val_b_d;
            r_addr_q <= r_addr_d;
            w_addr_q <= w_addr_d;
            din_q    <= din_d;
            wr_en_q  <= wr_en_d;
        end
    end

endmodule

// File: tb/tb_swap_regfile_ctrl.sv
// Bench for swap_regfile_ctrl: one instance with a registered-read regfile (RD_LAT=1),
// one with a combinational-read regfile (RD_LAT=0).
module tb_swap_regfile_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start1, start0;
    logic [4:0] addr_a, addr_b;
    logic       busy1, done1, wr1, busy0, done0, wr0;
    logic [4:0] ra1, wa1, ra0, wa0;
    logic [7:0] din1, dout1, din0, dout0;
    logic       pl_en;
    logic [4:0] pl_addr;
    logic [7:0] pl_dat;
    logic [7:0] mem1 [32];
    logic [7:0] mem0 [32];
    logic [7:0] ref_m [2][32];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    swap_regfile_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .addr_a(addr_a), .addr_b(addr_b),
        .busy(busy1), .done(done1), .rf_r_addr(ra1), .rf_dout(dout1),
        .rf_w_addr(wa1), .rf_din(din1), .rf_wr_en(wr1));

    swap_regfile_ctrl #(.ADDR_W(5), .DATA_W(8), .RD_LAT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .addr_a(addr_a), .addr_b(addr_b),
        .busy(busy0), .done(done0), .rf_r_addr(ra0), .rf_dout(dout0),
        .rf_w_addr(wa0), .rf_din(din0), .rf_wr_en(wr0));

    // Regfile models: contents survive reset.
    always @(posedge clk) begin
        if (wr1) mem1[wa1] <= din1;
        else if (pl_en) mem1[pl_addr] <= pl_dat;
        if (wr0) mem0[wa0] <= din0;
        else if (pl_en) mem0[pl_addr] <= pl_dat;
        dout1 <= mem1[ra1];
    end
    assign dout0 = mem0[ra0];

    typedef struct {
        int         sel;
        bit         pre;
        logic [4:0] a, b;
        int         x1, x2;
        int         lat, nwr;
        logic [4:0] ca0;
        logic [7:0] cv0;
        logic [4:0] ca1;
        logic [7:0] cv1;
    } vec_t;

    vec_t tbl [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    task automatic ds(input int sel, input logic v);
        if (sel != 0) start1 = v;
        else start0 = v;
    endtask

    function automatic logic [7:0] rdm(input int sel, input int i);
        return (sel != 0) ? mem1[i] : mem0[i];
    endfunction

    task automatic preload(input logic [4:0] ad, input logic [7:0] v);
        pl_en = 1'b1; pl_addr = ad; pl_dat = v;
        tick();
        pl_en = 1'b0;
        ref_m[0][ad] = v;
        ref_m[1][ad] = v;
    endtask

    task automatic mem_sweep(input int sel, input string nm);
        int bad;
        bad = 0;
        for (int i = 0; i < 32; i++)
            if (rdm(sel, i) !== ref_m[sel][i]) bad++;
        chk(nm, bad, 0);
    endtask

    // Starts a swap in the current cycle T and returns in T+lat+1 (first idle cycle).
    task automatic run(input int sel, input logic [4:0] a, input logic [4:0] b,
                       input int x1, input int x2, input logic [4:0] xa, input logic [4:0] xb,
                       input int lat, input int nwr);
        logic [15:0] bt, dt, bx, dx;
        logic [7:0]  tmp;
        int          wrc;
        bt = '0; dt = '0; bx = '0; dx = '0; wrc = 0;
        addr_a = a; addr_b = b;
        ds(sel, 1'b1);
        for (int k = 1; k <= lat + 1; k++) begin
            tick();
            ds(sel, 1'b0);
            bt[k] = (sel != 0) ? busy1 : busy0;
            dt[k] = (sel != 0) ? done1 : done0;
            if (((sel != 0) ? wr1 : wr0) === 1'b1) wrc++;
            bx[k] = (k <= lat);
            dx[k] = (k == lat);
            if (k == x1 || k == x2) begin
                addr_a = xa; addr_b = xb;
                ds(sel, 1'b1);
            end
        end
        ds(sel, 1'b0);
        chk($sformatf("busy_trace dut%0d a=%0d b=%0d", sel, a, b), {16'h0, bt}, {16'h0, bx});
        chk($sformatf("done_trace dut%0d a=%0d b=%0d", sel, a, b), {16'h0, dt}, {16'h0, dx});
        chk($sformatf("write_count dut%0d a=%0d b=%0d", sel, a, b), wrc, nwr);
        if (a != b) begin
            tmp = ref_m[sel][a];
            ref_m[sel][a] = ref_m[sel][b];
            ref_m[sel][b] = tmp;
        end
        mem_sweep(sel, $sformatf("contents dut%0d a=%0d b=%0d", sel, a, b));
    endtask

    initial begin
        logic [15:0] dv;
        rst_n = 1'b0; start1 = 1'b0; start0 = 1'b0; addr_a = '0; addr_b = '0;
        pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
        tick(); tick();
        chk("reset_outputs dut1", {9'h0, busy1, done1, wr1, ra1, wa1, din1}, 32'h0);
        chk("reset_outputs dut0", {9'h0, busy0, done0, wr0, ra0, wa0, din0}, 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 32; i++) preload(5'(i), 8'($urandom));
        preload(5'd5, 8'h5A);
        preload(5'd0, 8'h11);
        preload(5'd31, 8'h22);

        tbl[0] = '{1, 1'b1, 5'd3, 5'd7,  0, 0, 6, 2, 5'd3,  8'hCD, 5'd7,  8'hAB};
        tbl[1] = '{1, 1'b0, 5'd5, 5'd5,  0, 0, 1, 0, 5'd5,  8'h5A, 5'd5,  8'h5A};
        tbl[2] = '{1, 1'b0, 5'd0, 5'd31, 2, 6, 6, 2, 5'd0,  8'h22, 5'd31, 8'h11};
        tbl[3] = '{1, 1'b1, 5'd3, 5'd7,  0, 0, 6, 2, 5'd3,  8'hCD, 5'd7,  8'hAB};
        tbl[4] = '{1, 1'b0, 5'd3, 5'd7,  0, 0, 6, 2, 5'd3,  8'hAB, 5'd7,  8'hCD};
        tbl[5] = '{0, 1'b1, 5'd3, 5'd7,  0, 0, 4, 2, 5'd3,  8'hCD, 5'd7,  8'hAB};

        for (int i = 0; i < 6; i++) begin
            if (tbl[i].pre) begin
                preload(5'd3, 8'hAB);
                preload(5'd7, 8'hCD);
            end
            run(tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].x1, tbl[i].x2, 5'd1, 5'd2,
                tbl[i].lat, tbl[i].nwr);
            chk($sformatf("vec%0d entry%0d", i, tbl[i].ca0), {24'h0, rdm(tbl[i].sel, tbl[i].ca0)}, {24'h0, tbl[i].cv0});
            chk($sformatf("vec%0d entry%0d", i, tbl[i].ca1), {24'h0, rdm(tbl[i].sel, tbl[i].ca1)}, {24'h0, tbl[i].cv1});
        end

        // Reset while the second write is on the bus.
        preload(5'd3, 8'hAB);
        preload(5'd7, 8'hCD);
        dv = '0;
        addr_a = 5'd3; addr_b = 5'd7; start1 = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            start1 = 1'b0;
            dv[k] = done1;
        end
        chk("wr_en_in_wr_b", {31'h0, wr1}, 32'h1);
        #2 rst_n = 1'b0;
        #1 chk("wr_en_async_drop", {31'h0, wr1}, 32'h0);
        chk("busy_in_reset", {31'h0, busy1}, 32'h0);
        tick(); dv[6] = done1;
        tick(); dv[7] = done1;
        rst_n = 1'b1;
        tick(); dv[8] = done1;
        chk("idle_after_reset", {30'h0, busy1, done1}, 32'h0);
        chk("done_never_pulsed", {16'h0, dv}, 32'h0);
        chk("reset_entry3", {24'h0, mem1[3]}, 32'hCD);
        chk("reset_entry7", {24'h0, mem1[7]}, 32'hCD);
        ref_m[1][3] = ref_m[1][7];
        mem_sweep(1, "reset_contents dut1");

        for (int n = 0; n < 24; n++) begin
            int sel, lat, x1, x2, gap;
            logic [4:0] a, b;
            sel = n % 2;
            a = 5'($urandom_range(31));
            b = ($urandom_range(3) == 0) ? a : 5'($urandom_range(31));
            lat = (a == b) ? 1 : 4 + 2 * sel;
            x1 = ($urandom_range(1) == 0) ? 0 : $urandom_range(lat, 1);
            x2 = $urandom_range(lat, 1);
            if ($urandom_range(2) == 0) preload(5'($urandom_range(31)), 8'($urandom));
            gap = $urandom_range(2);
            for (int g = 0; g < gap; g++) tick();
            run(sel, a, b, x1, x2, 5'($urandom_range(31)), 5'($urandom_range(31)),
                lat, (a == b) ? 0 : 2);
        end
        mem_sweep(0, "final_contents dut0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
